// File: rtl/i2c_slave_mem_node_pkg.sv
// Shared types and constants for the I2C memory-mapped target.
package i2c_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    RW       = 4'd2,
    ADDR_ACK = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_ACK  = 4'd5,
    WR_DATA  = 4'd6,
    WR_ACK   = 4'd7,
    RD_DATA  = 4'd8,
    RD_ACK   = 4'd9
  } i2c_state_t;

endpackage

// File: rtl/i2c_slave_mem_node_if.sv
// Open-drain I2C bus view: master drives SCL and the resolved SDA, target pulls SDA low via sda_oe.
interface i2c_slave_mem_node_if;
  logic scl;
  logic sda_i;
  logic sda_oe;

  modport master (output scl, output sda_i, input sda_oe);
  modport slave  (input scl, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_mem256x8.sv
// Byte-wide register file: synchronous write, combinational read, reset loads mem[i] = i.
module i2c_mem256x8
  import i2c_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_c
);

  function automatic logic [MEM_DEPTH-1:0][DATA_W-1:0] init_pattern();
    logic [MEM_DEPTH-1:0][DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MEM_DEPTH; i++) v[ADDR_W'(i)] = DATA_W'(i);
    return v;
  endfunction

  localparam logic [MEM_DEPTH-1:0][DATA_W-1:0] MEM_INIT = init_pattern();

  logic [MEM_DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     mem       <= MEM_INIT;
    else if (wr_en) mem[addr] <= wr_data;
  end

  assign rd_data_c = mem[addr];

endmodule

// File: rtl/i2c_slave_mem_node.sv
// I2C target with 8-bit device ID match and a 256x8 register memory behind an 8-bit pointer.
module i2c_slave_mem_node
  import i2c_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     id,
  i2c_slave_mem_node_if.slave   bus,
  output logic [3:0]            state,
  output logic [DATA_W-1:0]     data_buffer
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  i2c_state_t        st;
  logic [3:0]        bit_cnt;
  logic              rw;
  logic              sda_oe_q;
  logic [ADDR_W-1:0] mem_address;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] shifted;

  // Synchronizers and one-deep history; idle bus level is high on both lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   =  scl_s & ~scl_q;
  assign scl_fall   = ~scl_s &  scl_q;
  assign start_cond =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_cond  =  scl_s &  scl_q & ~sda_q &  sda_s;
  assign shifted    = {data_buffer[DATA_W-2:0], sda_s};

  // In slave-ACK states sda_oe_q doubles as the phase flag: 0 on the fall that
  // opens the ACK slot, 1 on the fall that closes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      sda_oe_q    <= 1'b0;
      data_buffer <= '0;
      bit_cnt     <= '0;
      mem_address <= '0;
      rw          <= 1'b0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_cond) begin
        st       <= DEV_ADDR;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_cond) begin
        st       <= IDLE;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
      end else if (scl_rise) begin
        case (st)
          DEV_ADDR: begin
            data_buffer <= shifted;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              st      <= RW;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RW: begin
            rw <= sda_s;
            st <= ADDR_ACK;
          end
          MEM_ADDR: begin
            data_buffer <= shifted;
            if (bit_cnt == 4'd7) begin
              mem_address <= shifted;
              bit_cnt     <= '0;
              st          <= MEM_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          WR_DATA: begin
            data_buffer <= shifted;
            if (bit_cnt == 4'd7) begin
              wr_en   <= 1'b1;
              wr_data <= shifted;
              bit_cnt <= '0;
              st      <= WR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_DATA: bit_cnt <= bit_cnt + 4'd1;
          RD_ACK: begin
            if (sda_s == ACK) mem_address <= mem_address + ADDR_W'(1);
            else              st          <= IDLE;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (st)
          ADDR_ACK: begin
            if (!sda_oe_q) begin
              if (data_buffer == id) sda_oe_q <= 1'b1;
              else                   st       <= IDLE;
            end else begin
              sda_oe_q <= 1'b0;
              st       <= MEM_ADDR;
            end
          end
          MEM_ACK: begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else if (rw) begin
              data_buffer <= rd_data;
              sda_oe_q    <= ~rd_data[DATA_W-1];
              bit_cnt     <= '0;
              st          <= RD_DATA;
            end else begin
              sda_oe_q <= 1'b0;
              st       <= WR_DATA;
            end
          end
          WR_ACK: begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q    <= 1'b0;
              mem_address <= mem_address + ADDR_W'(1);
              st          <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              st       <= RD_ACK;
            end else begin
              data_buffer <= {data_buffer[DATA_W-2:0], 1'b0};
              sda_oe_q    <= ~data_buffer[DATA_W-2];
            end
          end
          RD_ACK: begin
            // Only reached after a master ACK; pointer was bumped on the rising edge
            data_buffer <= rd_data;
            sda_oe_q    <= ~rd_data[DATA_W-1];
            bit_cnt     <= '0;
            st          <= RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end

  assign state      = st;
  assign bus.sda_oe = sda_oe_q;

  i2c_mem256x8 #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .addr      (mem_address),
    .wr_data   (wr_data),
    .rd_data_c (rd_data)
  );

endmodule

// File: tb/tb_i2c_slave_mem_node.sv
// Bit-banged I2C master with a reference memory model and an expected-value queue.
module tb_i2c_slave_mem_node;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] id;
  logic       sda_m;
  logic [3:0] state;
  logic [7:0] data_buffer;
  logic [7:0] model [256];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  i2c_slave_mem_node_if bus();
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  always #5 clk = ~clk;

  i2c_slave_mem_node #(.MEM_DEPTH(256), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .id          (id),
    .bus         (bus.slave),
    .state       (state),
    .data_buffer (data_buffer)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 256; i++) model[i] = 8'(i);
  endtask

  // One SCL period, starting and ending with SCL low; samples SDA mid-high
  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;   #40;
    bus.scl = 1; #40;
    s = bus.sda_i; #40;
    bus.scl = 0; #40;
  endtask

  task automatic bus_start();
    sda_m = 1;   #40;
    bus.scl = 1; #40;
    sda_m = 0;   #40;
    bus.scl = 0; #40;
  endtask

  task automatic bus_stop();
    sda_m = 0;   #40;
    bus.scl = 1; #40;
    sda_m = 1;   #40;
  endtask

  task automatic send_dev(input logic [7:0] a, input logic rwb, input logic exp_ack);
    logic s;
    sb_push("dev_ack", 32'(exp_ack));
    for (int i = 7; i >= 0; i--) bus_bit(a[i], s);
    bus_bit(rwb, s);
    bus_bit(1'b1, s);
    sb_pop(32'(s));
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic s;
    sb_push(tag, 32'(exp_ack));
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    sb_pop(32'(s));
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp, input logic mack);
    logic [7:0] v;
    logic       s;
    sb_push(tag, 32'(exp));
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      v[i] = s;
      if (i == 5) check("rd_state_data", 32'(state), 32'(RD_DATA));
    end
    sb_pop(32'(v));
    check("rd_state_ack", 32'(state), 32'(RD_ACK));
    bus_bit(mack, s);
  endtask

  task automatic read_at(input logic [7:0] a, input int n);
    logic [7:0] ad;
    bus_start();
    send_dev(id, 1'b1, ACK);
    send_byte("rd_maddr_ack", a, ACK);
    for (int i = 0; i < n; i++) begin
      ad = 8'(a + 8'(i));
      read_byte($sformatf("rd_%02h", ad), model[ad], (i == n - 1) ? NACK : ACK);
    end
    bus_stop();
    check("rd_end_idle", 32'(state), 32'(IDLE));
  endtask

  task automatic write_at(input logic [7:0] a, input logic [7:0] d);
    bus_start();
    send_dev(id, 1'b0, ACK);
    send_byte("wr_maddr_ack", a, ACK);
    send_byte("wr_data_ack", d, ACK);
    model[a] = d;
    bus_stop();
  endtask

  initial begin
    logic s;
    bus.scl = 1;
    sda_m   = 1;
    id      = 8'h01;
    reset   = 0;
    model_init();
    repeat (3) @(negedge clk);
    check("rst_state",  32'(state),      32'(IDLE));
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst_dbuf",   32'(data_buffer), 32'd0);
    reset = 1;
    repeat (4) @(negedge clk);

    // Read mem[1] with master ACK, then NACK the following byte
    bus_start();
    check("start_state", 32'(state), 32'(DEV_ADDR));
    send_dev(8'h01, 1'b1, ACK);
    send_byte("rd_maddr_ack", 8'h01, ACK);
    read_byte("rd_01", model[8'h01], ACK);
    read_byte("rd_02", model[8'h02], NACK);
    bus_stop();
    check("stop_idle", 32'(state), 32'(IDLE));

    // Write 0x7F to mem[2], then repeated START and read it back
    bus_start();
    send_dev(8'h01, 1'b0, ACK);
    send_byte("wr_maddr_ack", 8'h02, ACK);
    send_byte("wr_data_ack", 8'h7F, ACK);
    model[8'h02] = 8'h7F;
    check("mem2_commit", 32'(dut.u_mem.mem[2]), 32'h7F);
    bus_start();
    send_dev(8'h01, 1'b1, ACK);
    send_byte("rd_maddr_ack", 8'h02, ACK);
    read_byte("rd_back_02", model[8'h02], NACK);
    bus_stop();

    // Device ID mismatch: no ACKs, nothing written
    bus_start();
    send_dev(8'h03, 1'b0, NACK);
    check("mismatch_idle",   32'(state),      32'(IDLE));
    check("mismatch_sda_oe", 32'(bus.sda_oe), 32'd0);
    send_byte("mm_maddr", 8'h05, NACK);
    send_byte("mm_data", 8'h99, NACK);
    bus_stop();
    read_at(8'h05, 1);

    // Burst write across the 0xFF -> 0x00 wrap, then burst read back
    bus_start();
    send_dev(id, 1'b0, ACK);
    send_byte("wr_maddr_ack", 8'hFF, ACK);
    send_byte("wr_data_ack", 8'hAA, ACK);
    model[8'hFF] = 8'hAA;
    send_byte("wr_data_ack", 8'h55, ACK);
    model[8'h00] = 8'h55;
    bus_stop();
    read_at(8'hFF, 2);

    // STOP after 4 data bits must not commit the partial byte
    bus_start();
    send_dev(id, 1'b0, ACK);
    send_byte("wr_maddr_ack", 8'h10, ACK);
    bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_bit(1'b0, s);
    bus_stop();
    check("abort_idle", 32'(state), 32'(IDLE));
    read_at(8'h10, 1);

    // Reset in the middle of a read byte
    write_at(8'h20, 8'h5A);
    check("mem20_commit", 32'(dut.u_mem.mem[8'h20]), 32'h5A);
    bus_start();
    send_dev(id, 1'b1, ACK);
    send_byte("rd_maddr_ack", 8'h20, ACK);
    bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    check("pre_rst_state", 32'(state), 32'(RD_DATA));
    reset = 0;
    #1;
    check("mid_rst_state",  32'(state),       32'(IDLE));
    check("mid_rst_sda_oe", 32'(bus.sda_oe),  32'd0);
    check("mid_rst_dbuf",   32'(data_buffer), 32'd0);
    model_init();
    repeat (2) @(negedge clk);
    reset = 1;
    sda_m = 1;
    #40;
    bus.scl = 1;
    #80;
    check("mem20_reinit", 32'(dut.u_mem.mem[8'h20]), 32'h20);
    check("memff_reinit", 32'(dut.u_mem.mem[8'hFF]), 32'hFF);
    read_at(8'h20, 2);
    read_at(8'h02, 1);
    read_at(8'hFF, 2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_mem_node.md
Name: i2c_slave_mem_node

Overview:
I2C target (slave) with an internal 256x8 register memory, matched against an 8-bit device ID.
- Oversamples SCL/SDA on the system clock.
- Decodes START / repeated START / STOP.
- Transfer format: 8-bit device address, R/W bit, 8-bit memory address, then data bytes (read or write).
- Sits on the shared I2C bus as an open-drain participant; the bus wrapper resolves sda_oe into the wired-AND SDA line.

Parameters:
- MEM_DEPTH, 256, number of memory bytes (address width 8).
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs.

Ports:
- clk  in  1  system clock, at least 8x the SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- id  in  8  device address this node answers to.
- scl  in  1  I2C clock from the bus (master-driven).
- sda_i  in  1  resolved SDA line value.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- state  out  4  current FSM state, for debug.
- data_buffer  out  8  current shift register contents, for debug.

Behaviour:
- Input conditioning:
  - scl and sda_i pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
- Bit timing:
  - SDA is sampled on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge.
  - Fields are MSB first.
- FSM states (4-bit encoding):
  - IDLE=0, DEV_ADDR=1, RW=2, ADDR_ACK=3, MEM_ADDR=4, MEM_ACK=5, WR_DATA=6, WR_ACK=7, RD_DATA=8, RD_ACK=9.
- DEV_ADDR: shift in 8 bits, then go to RW.
- RW: sample 1 bit (1 = read, 0 = write), then go to ADDR_ACK.
- ADDR_ACK:
  - If the shifted address == id, drive ACK (sda_oe=1) for this SCL high period.
  - On mismatch, keep sda_oe=0 and return to IDLE.
- MEM_ADDR: shift in 8 bits into mem_address, then go to MEM_ACK (slave drives ACK).
- Read path:
  - On the SCL falling edge ending MEM_ACK with rw=1, load mem[mem_address] into the shift register and enter RD_DATA.
  - RD_DATA: on each SCL fall, drive sda_oe = ~bit (bit 0 pulls low, bit 1 releases). After 8 bits, release and go to RD_ACK.
  - RD_ACK: master ACK (SDA=0) → mem_address+1 (wraps 255→0), reload, back to RD_DATA.
  - RD_ACK: master NACK → IDLE (wait for STOP).
- Write path:
  - WR_DATA: shift in 8 bits.
  - One clk after the 8th rising edge, write mem[mem_address] <= byte.
  - Then WR_ACK: slave drives ACK. On the SCL fall ending it, mem_address+1 (wraps) and back to WR_DATA.
- Start/stop override:
  - START or repeated START in any state → DEV_ADDR, bit counter cleared, sda_oe=0.
  - STOP in any state → IDLE, sda_oe=0.
  - START/STOP detection takes priority over bit sampling in the same clk.
  - A START/STOP in the middle of a byte aborts it; a partial write byte is never committed.
- Reset (asynchronous, also mid-transfer):
  - state=IDLE, sda_oe=0, data_buffer=0, bit counter=0, mem_address=0.
  - Memory reinitialised to mem[i]=i.

Decomposition:
- Package i2c_pkg:
  - i2c_state_t enum, with the encodings above.
  - ACK=0 / NACK=1 constants.
  - ADDR_W=8 and DATA_W=8.
- One sub-module, i2c_mem256x8:
  - Synchronous write, combinational read.
  - Async active-low reset init mem[i]=i.
- Top holds the synchronizers, edge/condition detect, FSM and shift register.

Test Plan:
- Read: START, addr 0x01 (id=0x01), R=1, mem addr 0x01, 8 SCLs, master ACK.
  - Slave ACKs both the address and memory-address slots.
  - Shifts out 0x01.
  - state reaches RD_DATA then RD_ACK.
- Write then read-back: STOP, START, addr 0x01 W, mem addr 0x02, data 0x7F.
  - mem[2]=0x7F after the 8th bit; slave ACK.
  - Repeated START, read addr 0x02 returns 0x7F.
- ID mismatch: id=0x01, master sends 0x03.
  - sda_oe stays 0 in ADDR_ACK; state returns to IDLE.
  - Memory unchanged.
- Burst with wrap: write 0xAA at 0xFF, then a second byte 0x55.
  - mem[0xFF]=0xAA, mem[0x00]=0x55.
  - A read burst from 0xFF with master ACK returns 0xAA then 0x55.
- Abort: STOP after 4 write-data bits → IDLE, target byte unchanged. Assert reset mid-RD_DATA → immediate IDLE, sda_oe=0, mem[i]=i.
